// File: rtl/aes128_pipelined.sv
// aes128_pipelined: fully pipelined AES-128 encryptor.
// One plaintext/key pair enters every clock and its ciphertext leaves 20
// cycles later. The key schedule travels down the pipe next to its block.
// Each round has two register stages: SubBytes/ShiftRows plus the next
// round key, then MixColumns/AddRoundKey.

// aes_sbox: combinational FIPS-197 S-box, one byte lane.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // The table is stored with entry 0x00 in the top byte.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx;

    // Entry a sits (255 - a) bytes above the bottom, and (255 - a) is simply ~a.
    assign idx = {~a, 3'b000};
    assign y   = TABLE[idx +: 8];
endmodule

module aes128_pipelined (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);
    localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    // data_b/key_b: round outputs (index 0 is the initial AddRoundKey).
    // data_a/key_a: mid-round registers after SubBytes/ShiftRows.
    logic [127:0] data_b [0:10];
    logic [127:0] key_b  [0:9];
    logic [127:0] data_a [1:10];
    logic [127:0] key_a  [1:10];

    // vld[s] marks a real block in the register s stages after capture.
    // It keeps out at 0 until the first real ciphertext arrives.
    logic [19:0]  vld;

    logic         Trojan_trigger;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] d);
        return {mix_column(d[127:96]), mix_column(d[95:64]),
                mix_column(d[63:32]),  mix_column(d[31:0])};
    endfunction

    // Stage 0: capture the block with the initial AddRoundKey, plus its key.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_b[0] <= '0;
            key_b[0]  <= '0;
        end else begin
            data_b[0] <= state ^ key;
            key_b[0]  <= key;
        end
    end

    // Valid marker shifts alongside the data; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld <= {vld[18:0], 1'b1};
        end
    end

    // Sticky debug pattern detector, observed only hierarchically.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Trojan_trigger <= 1'b0;
        end else if (state == 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin
            Trojan_trigger <= 1'b1;
        end
    end

    genvar r, b, c, row;
    for (r = 1; r <= 10; r++) begin : g_round
        logic [127:0] sub_bytes;
        logic [127:0] shifted;
        logic [127:0] mixed;
        logic [127:0] next_key;
        logic [127:0] prev_data;
        logic [127:0] prev_key;
        logic [31:0]  rot_word;
        logic [31:0]  sub_word;
        logic [31:0]  key_temp;
        logic [31:0]  w0, w1, w2, w3;
        logic         keep;

        assign prev_data = data_b[r-1];
        assign prev_key  = key_b[r-1];

        for (b = 0; b < 16; b++) begin : g_sb
            aes_sbox u_sbox (
                .a(prev_data[127-8*b -: 8]),
                .y(sub_bytes[127-8*b -: 8])
            );
        end

        // ShiftRows: row r of column c takes the byte from column (c + r) mod 4.
        for (c = 0; c < 4; c++) begin : g_col
            for (row = 0; row < 4; row++) begin : g_row
                assign shifted[127-8*(4*c+row) -: 8] =
                    sub_bytes[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end

        assign rot_word = {prev_key[23:0], prev_key[31:24]};

        for (b = 0; b < 4; b++) begin : g_ksb
            aes_sbox u_sbox (
                .a(rot_word[31-8*b -: 8]),
                .y(sub_word[31-8*b -: 8])
            );
        end

        assign key_temp = sub_word ^ {RCON[87-8*r -: 8], 24'h000000};
        assign w0       = prev_key[127:96] ^ key_temp;
        assign w1       = prev_key[95:64]  ^ w0;
        assign w2       = prev_key[63:32]  ^ w1;
        assign w3       = prev_key[31:0]   ^ w2;
        assign next_key = {w0, w1, w2, w3};

        if (r < 10) begin : g_mix
            assign mixed = mix_columns(data_a[r]);
            assign keep  = 1'b1;
        end else begin : g_last
            assign mixed = data_a[r];
            assign keep  = vld[19];
        end

        // First half of the round: substituted/shifted data and this round's key.
        always_ff @(posedge clk) begin
            if (!reset) begin
                data_a[r] <= '0;
                key_a[r]  <= '0;
            end else begin
                data_a[r] <= shifted;
                key_a[r]  <= next_key;
            end
        end

        // Second half of the round: AddRoundKey; the last round's register is out.
        always_ff @(posedge clk) begin
            if (!reset) begin
                data_b[r] <= '0;
            end else begin
                data_b[r] <= keep ? (mixed ^ key_a[r]) : '0;
            end
        end

        if (r < 10) begin : g_keyreg
            // Hand the round key on so the next round can expand from it.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    key_b[r] <= '0;
                end else begin
                    key_b[r] <= key_a[r];
                end
            end
        end
    end

    assign out = data_b[10];
endmodule

// File: tb/tb_aes128_pipelined.sv
// tb_aes128_pipelined: known-answer vectors plus a reference-model scoreboard
// for the pipelined AES-128 core, including mid-stream reset and the debug flag.
module tb_aes128_pipelined;
    logic         clk;
    logic         reset;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;

    int pass_count;
    int check_count;

    logic [127:0] pipe [$];
    logic [7:0]   sbox_t [256];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [5];

    localparam logic [127:0] DEAD    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] FIPSKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes128_pipelined dut (
        .clk  (clk),
        .reset(reset),
        .state(state),
        .key  (key),
        .out  (out)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, checks passed %0d of %0d", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Build the S-box from the GF(2^8) inverse and the affine map.
    task automatic buildSbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] aesModel(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [16];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            tmp[0] = sbox_t[w[13]] ^ rc;
            tmp[1] = sbox_t[w[14]];
            tmp[2] = sbox_t[w[15]];
            tmp[3] = sbox_t[w[12]];
            for (int i = 0; i < 4; i++)  w[i] = w[i] ^ tmp[i];
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
            rc = gmul(rc, 8'h02);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Pop the oldest in-flight expectation and compare it with out.
    task automatic checkOutput(input string name);
        logic [127:0] exp;
        exp = pipe.pop_front();
        checkVal(name, out, exp);
    endtask

    // Drive one edge; reset edges flush the model, others check then push.
    task automatic applyStimulus(input string name, input logic rst, input logic [127:0] st,
                                 input logic [127:0] k, input logic have_exp,
                                 input logic [127:0] exp_ct);
        @(negedge clk);
        reset = rst;
        state = st;
        key   = k;
        @(posedge clk);
        #1;
        if (!rst) begin
            pipe.delete();
            repeat (20) pipe.push_back('0);
            checkVal({name, "_reset_out"}, out, '0);
        end else begin
            checkOutput(name);
            pipe.push_back(have_exp ? exp_ct : aesModel(st, k));
        end
    endtask

    // Main sequence: reset, known answers, streaming, mid-stream reset, debug flag.
    initial begin
        pass_count  = 0;
        check_count = 0;
        reset = 1'b0;
        state = '0;
        key   = '0;
        buildSbox();

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, FIPSKEY,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h0, 128'h1, 128'h0545aad56da2a97c3663d1432a3d1c84};
        vecs[4] = '{128'h1, 128'h0, 128'h58e2fccefa7e3061367f1d57a4e7455a};

        for (int i = 0; i < 3; i++) begin
            applyStimulus("init", 1'b0, (i == 2) ? DEAD : rand128(), rand128(), 1'b0, '0);
            checkBit("init_trigger", dut.Trojan_trigger, 1'b0);
        end

        for (int i = 0; i < 5; i++)
            applyStimulus("kat", 1'b1, vecs[i].pt, vecs[i].key, 1'b1, vecs[i].ct);
        for (int i = 0; i < 24; i++)
            applyStimulus("stream", 1'b1, rand128(), rand128(), 1'b0, '0);

        applyStimulus("midreset", 1'b0, rand128(), rand128(), 1'b0, '0);
        checkBit("midreset_trigger", dut.Trojan_trigger, 1'b0);
        for (int i = 0; i < 25; i++)
            applyStimulus("post_reset", 1'b1, rand128(), rand128(), 1'b0, '0);

        applyStimulus("dead", 1'b1, DEAD, FIPSKEY, 1'b0, '0);
        checkBit("trigger_set", dut.Trojan_trigger, 1'b1);
        for (int i = 0; i < 50; i++) begin
            applyStimulus("dead_drain", 1'b1, rand128(), rand128(), 1'b0, '0);
            checkBit("trigger_sticky", dut.Trojan_trigger, 1'b1);
        end

        applyStimulus("final", 1'b0, DEAD, FIPSKEY, 1'b0, '0);
        checkBit("trigger_cleared", dut.Trojan_trigger, 1'b0);
        applyStimulus("final", 1'b1, vecs[0].pt, vecs[0].key, 1'b1, vecs[0].ct);
        checkBit("trigger_after_clear", dut.Trojan_trigger, 1'b0);
        for (int i = 0; i < 21; i++)
            applyStimulus("final_drain", 1'b1, rand128(), rand128(), 1'b0, '0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/aes128_pipelined.md
Name: aes128_pipelined

Overview:
Fully pipelined AES-128 encryption core: one 128-bit plaintext block and one 128-bit key accepted every clock, ciphertext emitted 20 cycles later. It sits in the crypto datapath as a streaming encryptor with no handshake; there is one block in flight per pipeline stage. It also carries a documented, sticky debug pattern-detect flag. The flag is observable only hierarchically and has no effect on the datapath.

Parameters:
None. Key size is fixed at 128 bits, round count at 10, latency at 20 cycles.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- state  input  128  plaintext block, bit 127 = first byte (FIPS-197 byte order).
- key  input  128  cipher key, same byte order.
- out  output  128  ciphertext, registered.

Behaviour:
- Reset (reset==0 at a rising edge): all pipeline registers clear to 0; out clears to 0; the debug flag clears to 0. Reset dominates all other activity and may be asserted mid-stream; every in-flight block is discarded.
- Algorithm: standard FIPS-197 AES-128 encryption.
  - Initial AddRoundKey.
  - 9 full rounds: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Final round without MixColumns.
- Key expansion is pipelined alongside the data: each stage receives its round key from the previous stage's key register, using rcon 01,02,04,08,10,20,40,80,1b,36. No key storage is shared between blocks.
- Pipeline:
  - Stage 0 registers state^key and key on the capture edge.
  - Each round uses two register stages: one for the key-schedule/S-box step and one for the round output. This gives 20 cycles total.
  - Plaintext captured at rising edge N appears on out immediately after rising edge N+20.
  - A new block and key are accepted every cycle; consecutive inputs yield consecutive outputs in order.
- Input values may change every cycle. Each block is paired only with the key sampled on the same edge.
- S-box: combinational 256-entry lookup, instantiated per byte lane per stage.
- Debug flag (internal register Trojan_trigger, 1 bit):
  - Set to 1 at any rising edge where reset==1 and state==128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF.
  - Sticky until reset.
  - Must never alter out, the key path, or timing.
- No X propagation after reset: out is defined (0) from the first reset edge, until valid data arrives 20 cycles after reset is released.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> out==0 and Trojan_trigger==0.
- FIPS-197 vector: release reset, then drive state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c at edge N -> out==3925841d02dc09fbdc118597196a0b32 after edge N+20.
- Back-to-back stream, one pair per cycle starting at edge N+1:
  - (00112233445566778899aabbccddeeff, 000102030405060708090a0b0c0d0e0f) -> out==69c4e0d86a7b0430d8cdb78070b4c55a at N+21.
  - (0, 0) -> out==66e94bd4ef8a2c3b884cfa59ca342b2e at N+22.
  - (0, 1) -> out==0545aad56da2a97c3663d1432a3d1c84 at N+23.
  - (1, 0) -> out==58e2fccefa7e3061367f1d57a4e7455a at N+24.
- Mid-stream reset: assert reset=0 for one edge while blocks are in flight -> out==0 on the next cycle, and no stale ciphertext appears afterward.
- Debug flag: after reset, drive state=DEADBEEF repeated 4 times with key=2b7e1516... -> Trojan_trigger==1 after the next edge and stays 1 for 50 cycles. out still equals the correct AES ciphertext of that block 20 cycles later. A subsequent reset clears the flag.
